// File: rtl/prog_loader.sv
// Program loader: streams instruction words into instruction memory, then
// releases the core from reset and waits for its eof before allowing a reload.
module prog_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] no_instruct,
    output logic              core_rst,
    input  logic              eof,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Handshake: a beat transfers on a rising edge where s_valid && s_ready;
    // the source holds s_data/s_last stable and keeps s_valid high until then.
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                s_ready_q, s_ready_d;
    logic                core_rst_q, core_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;

    assign accept = s_valid && s_ready_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    // A full memory drops the beat and aborts the load.
                    if (count_q == CNT_MAX) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = count_q;
                        mem_wdata_d = s_data;
                        count_d     = count_q + 1'b1;
                        if (s_last) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH:   state_d = RUN;
            RUN: begin
                if (eof) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        s_ready_d  = (state_d == LOAD);
        busy_d     = (state_d == LOAD) || (state_d == FLUSH) || (state_d == RUN);
        done_d     = (state_d == DONE);
        core_rst_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            s_ready_q   <= 1'b0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            s_ready_q   <= s_ready_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign no_instruct = count_q;
    assign core_rst    = core_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: random program loads checked against a queue-based
// model of the memory writes plus explicit release/run/reload/reset checks.
module tb_prog_loader;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int MAXW   = (1 << ADDR_W) - 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] no_instruct;
    logic              core_rst;
    logic              eof;
    logic              busy;
    logic              done;
    logic              err;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .no_instruct (no_instruct),
        .core_rst    (core_rst),
        .eof         (eof),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int we_cnt   = 0;
    int model_cnt = 0;
    logic model_err = 1'b0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] mon_e;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Every write pulse must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            we_cnt++;
            check_eq("we_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_eq("wr_addr", 64'(mem_addr), 64'(mon_e[ADDR_W+DATA_W-1:DATA_W]));
                check_eq("wr_data", 64'(mem_wdata), 64'(mon_e[DATA_W-1:0]));
                check_eq("no_instruct_wr", 64'(no_instruct),
                         64'(mon_e[ADDR_W+DATA_W-1:DATA_W]) + 64'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        model_cnt = 0;
        model_err = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic last, input int gap);
        int budget;
        budget  = 50;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && budget > 0) begin
            cyc(1);
            budget--;
        end
        if (budget == 0) begin
            check_eq("accept_timeout", 64'(s_ready), 64'd1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
        end
        // Model: memory holds at most MAXW words; a beat beyond that is lost.
        if (model_cnt < MAXW) begin
            exp_q.push_back({ADDR_W'(model_cnt), d});
            model_cnt++;
        end else begin
            model_err = 1'b1;
        end
        cyc(1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = $urandom;
        cyc(gap);
    endtask

    task automatic load(input int n, input logic last_on_final, input int gap_max);
        for (int i = 0; i < n; i++) begin
            if (last_on_final && i == n - 1)
                send_word($urandom, 1'b1, 0);
            else
                send_word($urandom, 1'b0, $urandom_range(0, gap_max));
        end
    endtask

    // Called right after the last beat was accepted: FLUSH cycle, then RUN.
    task automatic check_release();
        @(negedge clk);
        check_eq("flush_core_rst", 64'(core_rst), 64'd1);
        check_eq("flush_s_ready", 64'(s_ready), 64'd0);
        check_eq("flush_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check_eq("run_core_rst", 64'(core_rst), 64'd0);
        check_eq("run_busy", 64'(busy), 64'd1);
        check_eq("run_no_instruct", 64'(no_instruct), 64'(model_cnt));
        check_eq("run_err", 64'(err), 64'(model_err));
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            cyc(1);
            budget--;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_eof();
        eof = 1'b1;
        cyc(1);
        eof = 1'b0;
        @(negedge clk);
        check_eq("done_flag", 64'(done), 64'd1);
        check_eq("done_core_rst", 64'(core_rst), 64'd1);
        check_eq("done_busy", 64'(busy), 64'd0);
        check_eq("done_no_instruct", 64'(no_instruct), 64'(model_cnt));
    endtask

    task automatic check_reset_values();
        check_eq("rst_s_ready", 64'(s_ready), 64'd0);
        check_eq("rst_mem_we", 64'(mem_we), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check_eq("rst_no_instruct", 64'(no_instruct), 64'd0);
        check_eq("rst_core_rst", 64'(core_rst), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        eof     = 1'b0;
        cyc(2);
        @(negedge clk);
        check_reset_values();
        rst = 1'b1;
        cyc(2);

        // Three words back to back
        we_cnt = 0;
        do_start();
        send_word(32'h00500093, 1'b0, 0);
        send_word(32'h00308113, 1'b0, 0);
        send_word(32'h002081B3, 1'b1, 0);
        check_release();
        drain();
        check_eq("three_we_cnt", 64'(we_cnt), 64'd3);

        // start during RUN is ignored
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        @(negedge clk);
        check_eq("ign_start_busy", 64'(busy), 64'd1);
        check_eq("ign_start_core_rst", 64'(core_rst), 64'd0);
        check_eq("ign_start_s_ready", 64'(s_ready), 64'd0);
        run_eof();

        // Overflow: 64 words, no last
        we_cnt = 0;
        do_start();
        load(64, 1'b0, 1);
        @(negedge clk);
        check_eq("ovf_err", 64'(err), 64'(model_err));
        check_eq("ovf_busy", 64'(busy), 64'd0);
        check_eq("ovf_done", 64'(done), 64'd0);
        check_eq("ovf_core_rst", 64'(core_rst), 64'd1);
        check_eq("ovf_s_ready", 64'(s_ready), 64'd0);
        check_eq("ovf_no_instruct", 64'(no_instruct), 64'(model_cnt));
        drain();

        // s_valid in IDLE is ignored
        s_valid = 1'b1;
        s_data  = $urandom;
        cyc(3);
        @(negedge clk);
        check_eq("idle_s_ready", 64'(s_ready), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);
        s_valid = 1'b0;
        cyc(1);
        check_eq("ovf_we_cnt", 64'(we_cnt), 64'd63);

        // Four words with stalls, eof pulsed during LOAD
        we_cnt = 0;
        do_start();
        @(negedge clk);
        check_eq("start_clears_err", 64'(err), 64'd0);
        check_eq("start_s_ready", 64'(s_ready), 64'd1);
        check_eq("start_no_instruct", 64'(no_instruct), 64'd0);
        send_word($urandom, 1'b0, 2);
        send_word($urandom, 1'b0, 2);
        eof = 1'b1;
        cyc(1);
        eof = 1'b0;
        @(negedge clk);
        check_eq("ign_eof_busy", 64'(busy), 64'd1);
        check_eq("ign_eof_core_rst", 64'(core_rst), 64'd1);
        check_eq("ign_eof_done", 64'(done), 64'd0);
        send_word($urandom, 1'b0, 2);
        send_word($urandom, 1'b1, 0);
        check_release();
        drain();
        check_eq("stall_we_cnt", 64'(we_cnt), 64'd4);
        run_eof();

        // Reload from DONE with two words
        we_cnt = 0;
        do_start();
        load(2, 1'b1, 2);
        check_release();
        drain();
        check_eq("reload_we_cnt", 64'(we_cnt), 64'd2);
        run_eof();

        // Asynchronous reset in the middle of a load
        do_start();
        load(5, 1'b0, 1);
        drain();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_values();
        cyc(2);
        rst = 1'b1;
        cyc(1);
        we_cnt = 0;
        do_start();
        load(3, 1'b1, 2);
        check_release();
        drain();
        check_eq("post_rst_we_cnt", 64'(we_cnt), 64'd3);
        run_eof();

        // Largest legal program: 63 words with last on the 63rd
        we_cnt = 0;
        do_start();
        load(MAXW, 1'b1, 0);
        check_release();
        drain();
        check_eq("max_we_cnt", 64'(we_cnt), 64'(MAXW));
        run_eof();

        cyc(2);
        check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that sits directly upstream of the multi-cycle RV32I core. It accepts a stream of 32-bit instruction words over a valid/ready handshake, writes them into instruction memory at consecutive word addresses and counts them. It then drives the core's `no_instruct` count and holds the core in reset until loading is complete. Once released, it watches the core's `eof` to detect program completion, then freezes the core and is ready to reload.

## Interface
- `ADDR_W`, default 6: word-address and count width. Capacity is 2^ADDR_W−1 words (63 by default).
- `DATA_W`, default 32: instruction word width.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load. Honoured only in IDLE or DONE.
- `s_valid`  in  1  the input word is valid.
- `s_ready`  out  1  the loader accepts a word this cycle.
- `s_data`  in  DATA_W  instruction word.
- `s_last`  in  1  marks the final word of the program.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_addr`  out  ADDR_W  word address for the write.
- `mem_wdata`  out  DATA_W  write data.
- `no_instruct`  out  ADDR_W  number of words loaded; goes to the core.
- `core_rst`  out  1  active-high hold-in-reset for the core.
- `eof`  in  1  program-finished flag from the core.
- `busy`  out  1  high in LOAD, FLUSH and RUN.
- `done`  out  1  high in DONE.
- `err`  out  1  sticky overflow flag. Cleared by `rst` or by an accepted `start`.

## Operation
- States: IDLE, LOAD, FLUSH, RUN, DONE. All outputs are registered.
- Reset values:
  - state = IDLE.
  - `s_ready`, `mem_we`, `busy`, `done`, `err` = 0.
  - `mem_addr`, `no_instruct`, `mem_wdata` = 0.
  - `core_rst` = 1.
- IDLE:
  - `start` → LOAD.
  - Clear the count, clear `err`, assert `s_ready`.
- LOAD:
  - A beat is accepted when `s_valid && s_ready`.
  - Each accepted beat writes the word to address = count, then increments the count.
  - `no_instruct` tracks the count.
- Last beat:
  - An accepted beat with `s_last` = 1 → FLUSH. `s_ready` drops in the following cycle.
- Overflow:
  - A beat accepted while count = 2^ADDR_W−1 is not written.
  - `err` is set, `s_ready` drops, and the state returns to IDLE.
  - `core_rst` stays 1.
- FLUSH:
  - One cycle, allowing the final memory write to complete.
  - → RUN.
- RUN:
  - `core_rst` = 0.
  - `eof` = 1 → DONE.
- DONE:
  - `core_rst` = 1 and `done` = 1.
  - `no_instruct` is held.
  - `start` → LOAD, with the count cleared.
- `start` in LOAD, FLUSH or RUN is ignored.
- `s_valid` outside LOAD is ignored (`s_ready` = 0).
- `eof` outside RUN is ignored.
- `s_data` and `s_last` must be stable while `s_valid` = 1 and `s_ready` = 0. A source may not retract `s_valid` before the beat is accepted.

## Timing
- Write latency: a beat accepted on edge N produces `mem_we` = 1 during cycle N+1, with `mem_addr` = count before the increment and `mem_wdata` = that beat's `s_data`.
- `mem_we` is a single-cycle pulse per accepted beat.
- Back-to-back beats give one write per cycle at increasing addresses.
- `no_instruct` becomes valid in the same cycle as the corresponding `mem_we`.
- Release timing for last beat accepted on edge N:
  - Edge N+1: FLUSH, with the last write in flight.
  - Edge N+2: RUN; `core_rst` falls during cycle N+2.
- `eof` sampled high on edge M → DONE; `core_rst` and `done` are high during cycle M+1.
- `start` plus `s_valid` in the IDLE cycle: `s_ready` is 0 in IDLE, so no beat is accepted. The first accept can happen in the first LOAD cycle.
- Reset asserted mid-load or mid-run:
  - Immediate return to the reset values, `core_rst` = 1.
  - Memory contents are left as they are.
  - The partial count is discarded.
- Maximum program is 63 words with the default parameters.
  - A 63rd beat carrying `s_last` is legal.
  - A 64th beat triggers the overflow path.

## Test plan
- Load three words with no stalls:
  - Stimulus: `start`, then words 0x00500093, 0x00308113, 0x002081B3 on consecutive cycles, `s_last` on the third.
  - Required: writes to addresses 0, 1, 2 with the same data; `no_instruct` = 3; `core_rst` falls 2 cycles after the last accept.
- Stalls on `s_valid`:
  - Stimulus: 4 words with 2 idle cycles between each.
  - Required: exactly 4 `mem_we` pulses at addresses 0–3; `no_instruct` = 4; no duplicate writes.
- Overflow:
  - Stimulus: 64 words, no `s_last`.
  - Required: 63 writes at addresses 0–62; `err` = 1; state IDLE; `core_rst` stays 1.
- Run to completion and reload:
  - Stimulus: after release, pulse `eof`.
  - Required: `done` = 1 and `core_rst` = 1 the next cycle.
  - Then `start` plus 2 words → `no_instruct` = 2, `err` = 0, writes at addresses 0 and 1.
- Reset mid-load:
  - Stimulus: drive `rst` low after 5 accepted words.
  - Required: all outputs return to their reset values asynchronously; a later `start` restarts writes at address 0.
- Ignored inputs:
  - Stimulus: `start` during RUN, `eof` during LOAD, `s_valid` in IDLE.
  - Required: no state change, no `mem_we` pulse.
